wb_pipelined_ram_slave: RTL

//  Wishbone B4 pipelined-mode responder: a single-port on-chip RAM sitting on one slave port of the shared-bus interconnect.

---
 rtl/wb_pipelined_ram_slave.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_pipelined_ram_slave.sv
// Wishbone B4 pipelined slave fronting a single-port RAM with fixed-latency in-order ack/err.
// The RAM is zeroed word-by-word after reset (stall held high) before traffic is served.
module wb_pipelined_ram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2,
  parameter bit          INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [3:0]  sel,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack,
  output logic        err,
  output logic        stall
);

  localparam int              AW       = $clog2(MEM_WORDS);
  localparam logic [AW-1:0]   LAST_IDX = AW'(MEM_WORDS - 1);
  localparam logic [31:0]     WINDOW   = 32'(MEM_WORDS * 4);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  localparam state_e RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

  state_e             state_r;
  state_e             state_next_s;
  logic               stall_s;
  logic               init_we_s;
  logic [AW-1:0]      init_cnt_r;
  logic [31:0]        off_s;
  logic               in_range_s;
  logic [AW-1:0]      idx_s;
  logic               accept_s;
  logic               ram_en_s;
  logic               ram_we_s;
  logic [AW-1:0]      ram_addr_s;
  logic [3:0]         ram_be_s;
  logic [31:0]        ram_wdata_s;
  logic [31:0]        mem_r [MEM_WORDS];
  logic [31:0]        ram_q_r;
  logic [LATENCY-1:0] ack_pipe_r;
  logic [LATENCY-1:0] err_pipe_r;
  logic               rd0_r;
  logic [31:0]        data0_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: leave INIT on the edge that clears the last word
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT: begin
        if (init_cnt_r == LAST_IDX) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_INIT;
        end
      end
      ST_RUN:  state_next_s = ST_RUN;
      default: state_next_s = RESET_STATE;
    endcase
  end

  // FSM outputs
  always_comb begin
    stall_s   = 1'b1;
    init_we_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        stall_s   = 1'b1;
        init_we_s = 1'b1;
      end
      ST_RUN: begin
        stall_s   = 1'b0;
        init_we_s = 1'b0;
      end
      default: begin
        stall_s   = 1'b1;
        init_we_s = 1'b0;
      end
    endcase
  end

  // Init word counter, restarts from word 0 on every reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt_r <= {AW{1'b0}};
    end else if (init_we_s) begin
      init_cnt_r <= init_cnt_r + AW'(1'b1);
    end else begin
      init_cnt_r <= {AW{1'b0}};
    end
  end

  // Address decode; the subtraction wraps so addresses below the base land out of range
  always_comb begin
    off_s      = adr - BASE_ADDR;
    in_range_s = (off_s < WINDOW);
    idx_s      = off_s[AW+1:2];
    accept_s   = cyc & stb & ~stall_s;
  end

  // Single RAM port shared between the init sweep and bus traffic
  always_comb begin
    if (init_we_s) begin
      ram_en_s    = 1'b1;
      ram_we_s    = 1'b1;
      ram_addr_s  = init_cnt_r;
      ram_be_s    = 4'hF;
      ram_wdata_s = 32'h0;
    end else begin
      ram_en_s    = accept_s & in_range_s;
      ram_we_s    = we;
      ram_addr_s  = idx_s;
      ram_be_s    = sel;
      ram_wdata_s = dat_i;
    end
  end

  // Synchronous single-port RAM with byte-lane writes
  always_ff @(posedge clk) begin
    if (ram_en_s && ram_we_s) begin
      for (int k = 0; k < 4; k++) begin
        if (ram_be_s[k]) begin
          mem_r[ram_addr_s][8*k +: 8] <= ram_wdata_s[8*k +: 8];
        end
      end
    end else if (ram_en_s) begin
      ram_q_r <= mem_r[ram_addr_s];
    end
  end

  // Response pipeline; dropping cyc discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pipe_r <= {LATENCY{1'b0}};
      err_pipe_r <= {LATENCY{1'b0}};
      rd0_r      <= 1'b0;
    end else if (!cyc) begin
      ack_pipe_r <= {LATENCY{1'b0}};
      err_pipe_r <= {LATENCY{1'b0}};
      rd0_r      <= 1'b0;
    end else begin
      ack_pipe_r[0] <= accept_s & in_range_s;
      err_pipe_r[0] <= accept_s & ~in_range_s;
      rd0_r         <= accept_s & in_range_s & ~we;
      for (int k = 1; k < LATENCY; k++) begin
        ack_pipe_r[k] <= ack_pipe_r[k-1];
        err_pipe_r[k] <= err_pipe_r[k-1];
      end
    end
  end

  // RAM output is only meaningful in the cycle after an in-range read
  always_comb begin
    if (rd0_r) begin
      data0_s = ram_q_r;
    end else begin
      data0_s = 32'h0;
    end
  end

  if (LATENCY == 1) begin : g_lat1
    assign dat_o = data0_s;
  end else begin : g_latn
    logic [31:0] data_pipe_r [1:LATENCY-1];

    // Read-data shift register, cleared alongside the valid bits
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 1; k < LATENCY; k++) begin
          data_pipe_r[k] <= 32'h0;
        end
      end else if (!cyc) begin
        for (int k = 1; k < LATENCY; k++) begin
          data_pipe_r[k] <= 32'h0;
        end
      end else begin
        data_pipe_r[1] <= data0_s;
        for (int k = 2; k < LATENCY; k++) begin
          data_pipe_r[k] <= data_pipe_r[k-1];
        end
      end
    end

    assign dat_o = data_pipe_r[LATENCY-1];
  end

  assign ack   = ack_pipe_r[LATENCY-1];
  assign err   = err_pipe_r[LATENCY-1];
  assign stall = stall_s;

endmodule
